// File: rtl/tt_chk_pkg.sv
// ============================================================================
// Module   : tt_chk_pkg
// Purpose  : Shared definitions for truth_table_checker: FSM state encoding,
//            minterm count and counter widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tt_chk_pkg;

  localparam int TT_N  = 16;  // number of 4-input minterms
  localparam int VEC_W = 4;   // stimulus width {A,B,C,D}
  localparam int ERR_W = 5;   // mismatch counter width

  localparam logic [ERR_W-1:0] ERR_MAX = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/truth_table_checker.sv
// ============================================================================
// Module   : truth_table_checker
// Purpose  : Exhaustive-coverage checker for a 4-input combinational function.
//            Each accepted sample {vec, f_in} is compared against the expected
//            truth table TT_EXP; coverage of all 16 minterms ends the run.
// Ports    : clk          - clock, rising edge
//            rst_n        - asynchronous active-low reset
//            start        - begin / restart a checking run
//            sample_valid - vec/f_in valid this cycle
//            vec[3:0]     - applied stimulus {A,B,C,D}, A is MSB
//            f_in         - observed F for vec
//            busy         - run in progress
//            done         - all 16 minterms covered
//            pass         - done with zero mismatches
//            err_cnt[4:0] - saturating mismatch count
//            cov_mask[15:0] - minterms sampled in the current run
//            fail_seen, fail_vec[3:0] - first mismatch capture
//                           (only when TT_FIRST_FAIL_EN is defined)
// Config   : TT_FIRST_FAIL_EN - adds first-failure capture outputs
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_checker
  import tt_chk_pkg::*;
#(
  parameter logic [TT_N-1:0] TT_EXP = 16'h6996
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [VEC_W-1:0] vec,
  input  logic             f_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [TT_N-1:0]  cov_mask
`ifdef TT_FIRST_FAIL_EN
  ,
  output logic             fail_seen,
  output logic [VEC_W-1:0] fail_vec
`endif
);

  state_t state;
  state_t state_nxt;

  logic [TT_N-1:0] vec_bit;
  logic            accept;
  logic            mismatch;
  logic            cov_full_nxt;

  assign vec_bit      = {{(TT_N-1){1'b0}}, 1'b1} << vec;
  // start has priority over a coincident sample, so a restart cycle never
  // contributes to the new run.
  assign accept       = (state == RUN) && sample_valid && !start;
  assign mismatch     = (f_in != TT_EXP[vec]);
  assign cov_full_nxt = ((cov_mask | vec_bit) == '1);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (start) begin
          state_nxt = RUN;
        end else if (sample_valid && cov_full_nxt) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Coverage mask and saturating mismatch counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cov_mask <= '0;
      err_cnt  <= '0;
    end else if (start) begin
      cov_mask <= '0;
      err_cnt  <= '0;
    end else if (accept) begin
      cov_mask <= cov_mask | vec_bit;
      if (mismatch && (err_cnt != ERR_MAX)) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

`ifdef TT_FIRST_FAIL_EN
  // --------------------------------------------------------------------------
  // First-failure capture: latches only the earliest mismatch of a run
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_seen <= 1'b0;
      fail_vec  <= '0;
    end else if (start) begin
      fail_seen <= 1'b0;
      fail_vec  <= '0;
    end else if (accept && mismatch && !fail_seen) begin
      fail_seen <= 1'b1;
      fail_vec  <= vec;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Status outputs, decoded from registered state and counters
  // --------------------------------------------------------------------------
  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = (state == DONE) && (err_cnt == '0);

endmodule

`default_nettype wire

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter TT_EXP, default 16'h6996, expected F for each 4-input minterm; bit index = {A,B,C,D}.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  pulse; begins or restarts a checking run.
REQ-005 sample_valid  input  1  vec/f_in carry one applied stimulus and its DUT response this cycle.
REQ-006 vec  input  4  applied stimulus {A,B,C,D}, A is MSB.
REQ-007 f_in  input  1  DUT output F for vec.
REQ-008 busy  output  1  high in RUN.
REQ-009 done  output  1  high in DONE; all 16 minterms covered.
REQ-010 pass  output  1  high in DONE only when err_cnt is zero.
REQ-011 err_cnt  output  5  mismatch count, saturating at 31.
REQ-012 cov_mask  output  16  bit n set once minterm n has been sampled in the current run.

Function
REQ-013 FSM states: IDLE, RUN, DONE; outputs registered, decoded from state and counters.
REQ-014 IDLE: start -> RUN next cycle; sample_valid ignored.
REQ-015 Entering RUN clears cov_mask, err_cnt and pass in the same edge.
REQ-016 RUN, sample_valid: cov_mask[vec] set next cycle; if f_in != TT_EXP[vec], err_cnt increments next cycle.
REQ-017 err_cnt at 31 holds at 31 on further mismatches.
REQ-018 Repeated vec in a run: re-checked and counted toward err_cnt; cov_mask unchanged.
REQ-019 The accepted sample that completes cov_mask == 16'hFFFF -> DONE on that edge; err_cnt includes that sample.
REQ-020 Latency: a sample's effect on cov_mask, err_cnt, done and pass is visible exactly one cycle after sample_valid.
REQ-021 DONE: done=1, pass=(err_cnt==0); both hold until start or reset; sample_valid ignored.
REQ-022 start in RUN or DONE: restart; state goes to RUN and counters clear next cycle.
REQ-023 start and sample_valid in the same cycle: start wins; the sample is discarded.
REQ-024 No run timeout; RUN persists until coverage completes, start, or reset.

Reset
REQ-025 rst_n low: state=IDLE; busy=0, done=0, pass=0, err_cnt=0, cov_mask=0, immediately, with no clock required.
REQ-026 Reset mid-run discards all progress; the first edge after release is evaluated from IDLE.

Configuration
REQ-027 Macro TT_FIRST_FAIL_EN defined: adds outputs fail_seen (1) and fail_vec (4).
REQ-028 fail_seen and fail_vec capture the vec of the first mismatch after run start, hold until the next start or reset, and reset to 0.
REQ-029 Macro undefined: those ports and their logic are absent; all other behaviour is identical.

Structure
REQ-030 Shared package tt_chk_pkg holds: state enum (IDLE/RUN/DONE), TT_N=16, VEC_W=4, ERR_W=5, ERR_MAX=31.
REQ-031 Single module; no sub-module is required, and the coverage mask and error counter stay inline.

Verification
REQ-032 Reset, then start; apply vec 0..15 in order with f_in=TT_EXP[vec] -> done=1, pass=1, err_cnt=0, cov_mask=16'hFFFF one cycle after vec=15.
REQ-033 As REQ-032 but f_in inverted at vec=5 and vec=10 -> done=1, pass=0, err_cnt=2; with macro: fail_seen=1, fail_vec=5.
REQ-034 Apply vec=3 four times, then 0..15 -> err_cnt=0, DONE only after vec=15; repeats do not complete coverage early.
REQ-035 Apply 40 mismatching samples on vec=0 -> err_cnt=31 and stays 31; cov_mask=16'h0001; busy=1.
REQ-036 start with sample_valid (vec=7) in the same cycle -> cov_mask=0 next cycle; assert rst_n low mid-run -> all outputs 0 asynchronously.
REQ-037 In DONE, apply sample_valid with a mismatching f_in -> err_cnt, pass and cov_mask unchanged; a following start -> busy=1, done=0, cov_mask=0.
